sfifo_rr_ctrl: RTL and testbench
================================

// Module: sfifo_rr_ctrl
// PURPOSE
//  Sequencer and arbiter for one sfifo instance. Shares the sfifo write port between NUM_REQ producers (round-robin).
//  Drives the sfifo read port on behalf of one consumer and presents read data on a valid/ready interface.
//  Sits directly beside the sfifo; all sfifo inputs come from registers in this block.
// PARAMETERS
//  NUM_REQ   4   number of producers
//  WIDTH     8   data width; equals sfifo FIFO_WIDTH
//  DEPTH     16  sfifo depth; equals FIFO_DEPTH
//  CNT_W     5   sfifo counter width (FIFO_BITS+1)
//  OQ_DEPTH  4   output queue entries; fixed at 4
// PORTS
//  clock         in   1              rising-edge clock
//  reset_n       in   1              asynchronous, active-low reset; the same net resets the sfifo
//  req_valid     in   NUM_REQ        producer i has a word
//  req_data      in   NUM_REQ*WIDTH  producer i word in bits [i*WIDTH +: WIDTH]
//  req_ready     out  NUM_REQ        one-hot grant; transfer when valid&ready at the rising edge
//  fifo_data_in  out  WIDTH          to sfifo data_in
//  fifo_write_n  out  1              to sfifo write_n, active low
//  fifo_read_n   out  1              to sfifo read_n, active low
//  fifo_data_out in   WIDTH          from sfifo data_out
//  fifo_counter  in   CNT_W          from sfifo counter
//  drain_en      in   1              1 = reads allowed; 0 = no new reads (in-flight reads complete)
//  out_valid     out  1              consumer data valid
//  out_data      out  WIDTH          consumer data, head of output queue
//  out_ready     in   1              consumer accepts when out_valid&out_ready at the rising edge
//  last_grant    out  log2(NUM_REQ)  index of most recent granted producer
//  err_ovf       out  1              sticky: write issued while fifo_counter==DEPTH
// BEHAVIOUR
//  Reset values:
//   - fifo_write_n=1, fifo_read_n=1, fifo_data_in=0.
//   - out_valid=0, out_data=0, req_ready=0.
//   - last_grant=NUM_REQ-1, so producer 0 wins first; err_ovf=0; output queue empty.
//   - Reset mid-operation discards in-flight words; it is not an error.
//  Write path:
//   - wr_room = (fifo_counter + ~fifo_write_n) < DEPTH. This accounts for a write registered but not yet counted.
//   - Pending reads are ignored (conservative).
//   - If wr_room: req_ready has one bit set, for the first valid requester searching upward from last_grant+1 mod NUM_REQ.
//     It is combinational from req_valid, last_grant and the registered state.
//   - If !wr_room or no valid requester: req_ready=0.
//   - On a transfer in cycle t:
//     * fifo_write_n=0 and fifo_data_in=req_data[grant] are registered for cycle t+1.
//     * last_grant is updated at the same edge.
//     * The sfifo counter rises at the end of t+1.
//   - Otherwise fifo_write_n=1; fifo_data_in holds its value.
//   - Throughput: 1 write/cycle while room exists. With all NUM_REQ requesting, each is granted once every NUM_REQ cycles.
//  Read path, 3-stage:
//   - rd_avail = (fifo_counter - ~fifo_read_n) > 0, evaluated without underflow. Pending writes are ignored.
//   - oq_space = q_count + s1 + s2 < OQ_DEPTH, where s1 = ~fifo_read_n and s2 = capture-stage flag.
//   - Issue in cycle t iff drain_en & rd_avail & oq_space: fifo_read_n=0 in t+1.
//   - sfifo data_out updates at the end of t+1. fifo_data_out is pushed into the queue at the end of t+2.
//   - out_valid rises in t+3, assuming an empty queue.
//   - The queue is FIFO-ordered. A push and a pop in the same cycle are allowed; q_count then stays unchanged.
//   - out_data is stable while out_valid=1 and out_ready=0.
//  Simultaneous events:
//   - A write and a read in the same cycle are both issued; the sfifo counter holds.
//   - The two accounting rules above keep fifo_counter in 0..DEPTH at all times.
//  err_ovf sets if fifo_write_n=0 while fifo_counter==DEPTH, and only reset clears it. It is never set in correct operation.
//  Arithmetic is widened to CNT_W+1 bits to avoid wrap.
// TESTING
//  1 Reset, then req_valid=0001, data 0x11, drain_en=0 -> req_ready=0001; fifo_write_n=0 one cycle later with fifo_data_in=0x11; last_grant=0.
//  2 req_valid=1111 held, drain_en=0 -> grants 0,1,2,3,0,1... for 16 accepts. req_ready=0 once counter+pending=16; counter stops at 16; err_ovf=0.
//  3 Load 0xA0..0xA3, drain_en=1, out_ready=1 -> fifo_read_n=0 one cycle after drain_en sampled; first out_valid 3 cycles after issue; data A0,A1,A2,A3 in order.
//  4 Full sfifo, out_ready=0, drain_en=1 -> exactly 4 reads issued, counter=12, out_data=first word held stable, no further fifo_read_n pulses.
//  5 Continuous 1-word/cycle producer 2 with drain_en=1 and out_ready=1 -> sustained 1/cycle both ends; counter stays within 0..2; no loss or reorder.
//  6 Assert reset_n=0 mid-burst for 1 cycle -> outputs return to reset values at once; first grant after release goes to producer 0.

Source files
------------

// File: rtl/sfifo_rr_ctrl_if.sv
// ---------------------------------------------------------------------------------------------
// sfifo_rr_ctrl_if: bundle of every non-clock signal around sfifo_rr_ctrl.
//   Producers : req_valid/req_data in, req_ready (one-hot grant) out
//   sfifo     : fifo_data_in/fifo_write_n/fifo_read_n out, fifo_data_out/fifo_counter in
//   Consumer  : drain_en/out_ready in, out_valid/out_data out
//   Status    : last_grant, err_ovf out
// The slave modport is the controller's view; master is the surrounding environment.
// ---------------------------------------------------------------------------------------------
interface sfifo_rr_ctrl_if #(
    parameter int unsigned NumReq = 4,
    parameter int unsigned Width  = 8,
    parameter int unsigned CntW   = 5,
    parameter int unsigned GntW   = (NumReq > 1) ? $clog2(NumReq) : 1
);
    logic [NumReq-1:0]       req_valid;
    logic [NumReq*Width-1:0] req_data;
    logic [NumReq-1:0]       req_ready;
    logic [Width-1:0]        fifo_data_in;
    logic                    fifo_write_n;
    logic                    fifo_read_n;
    logic [Width-1:0]        fifo_data_out;
    logic [CntW-1:0]         fifo_counter;
    logic                    drain_en;
    logic                    out_valid;
    logic [Width-1:0]        out_data;
    logic                    out_ready;
    logic [GntW-1:0]         last_grant;
    logic                    err_ovf;

    modport slave (
        input  req_valid, req_data, fifo_data_out, fifo_counter, drain_en, out_ready,
        output req_ready, fifo_data_in, fifo_write_n, fifo_read_n, out_valid, out_data,
               last_grant, err_ovf
    );

    modport master (
        output req_valid, req_data, fifo_data_out, fifo_counter, drain_en, out_ready,
        input  req_ready, fifo_data_in, fifo_write_n, fifo_read_n, out_valid, out_data,
               last_grant, err_ovf
    );
endinterface

// File: rtl/sfifo_rr_ctrl.sv
// ---------------------------------------------------------------------------------------------
// sfifo_rr_ctrl: sequencer/arbiter sitting beside one sfifo.
//   - Round-robin arbitration of NumReq producers onto the sfifo write port.
//   - Three-stage read pipeline (issue, sfifo access, capture) feeding a 4-entry output queue
//     presented to one consumer on a valid/ready interface.
//   - All sfifo inputs are driven from registers.
// Ports:
//   clock    rising-edge clock
//   reset_n  asynchronous active-low reset (shared with the sfifo)
//   bus_io   slave view of sfifo_rr_ctrl_if (producer, sfifo, consumer and status signals)
// ---------------------------------------------------------------------------------------------
module sfifo_rr_ctrl #(
    parameter int unsigned NumReq  = 4,
    parameter int unsigned Width   = 8,
    parameter int unsigned Depth   = 16,
    parameter int unsigned CntW    = 5,
    parameter int unsigned OqDepth = 4
) (
    input logic            clock,
    input logic            reset_n,
    sfifo_rr_ctrl_if.slave bus_io
);
    localparam int unsigned GntW  = (NumReq > 1) ? $clog2(NumReq) : 1;
    localparam int unsigned AccW  = CntW + 1;
    localparam int unsigned QPtrW = $clog2(OqDepth);
    localparam int unsigned QCntW = QPtrW + 1;
    localparam int unsigned QLvlW = QCntW + 1;

    // Write path state
    logic             write_n_q, write_n_d;
    logic [Width-1:0] data_in_q, data_in_d;
    logic [GntW-1:0]  last_grant_q, last_grant_d;
    logic             err_ovf_q, err_ovf_d;

    // Read path state
    logic             read_n_q, read_n_d;   // stage 1: read strobe to the sfifo
    logic             cap_q, cap_d;         // stage 2: sfifo data_out valid this cycle
    logic [Width-1:0] oq_mem_q [OqDepth];
    logic [QPtrW-1:0] oq_wr_ptr_q, oq_rd_ptr_q;
    logic [QCntW-1:0] oq_cnt_q, oq_cnt_d;

    // Arbitration
    logic [NumReq-1:0] gnt_oh;
    logic [GntW-1:0]   gnt_idx;
    logic [Width-1:0]  gnt_data;
    logic              gnt_found;
    logic [NumReq-1:0] req_ready;
    logic              transfer;

    logic [AccW-1:0]  cnt_w;
    logic [AccW-1:0]  wr_level;
    logic             wr_room;
    logic             rd_avail;
    logic [QLvlW-1:0] oq_level;
    logic             oq_space;
    logic             rd_issue;
    logic             oq_push;
    logic             oq_pop;
    logic             out_valid;

    // Occupancy as seen by each port: a registered write not yet counted uses up room, a
    // registered read not yet counted uses up an available word.
    always_comb begin
        cnt_w    = AccW'(bus_io.fifo_counter);
        wr_level = cnt_w + AccW'(!write_n_q);
        wr_room  = wr_level < AccW'(Depth);
        rd_avail = cnt_w > AccW'(!read_n_q);
        oq_level = QLvlW'(oq_cnt_q) + QLvlW'(!read_n_q) + QLvlW'(cap_q);
        oq_space = oq_level < QLvlW'(OqDepth);
        rd_issue = bus_io.drain_en & rd_avail & oq_space;
    end

    // Search upward from last_grant+1 (mod NumReq) for the first valid requester.
    always_comb begin
        int unsigned idx;
        gnt_oh    = '0;
        gnt_idx   = '0;
        gnt_data  = '0;
        gnt_found = 1'b0;
        idx       = 0;
        for (int unsigned k = 1; k <= NumReq; k++) begin
            idx = (32'(last_grant_q) + k) % NumReq;
            if (!gnt_found && bus_io.req_valid[idx]) begin
                gnt_found   = 1'b1;
                gnt_idx     = GntW'(idx);
                gnt_oh[idx] = 1'b1;
                gnt_data    = bus_io.req_data[idx*Width +: Width];
            end
        end
    end

    // Grants are suppressed while reset is held so the bus shows its reset state at once.
    assign req_ready = (reset_n && wr_room) ? gnt_oh : '0;
    assign transfer  = |(bus_io.req_valid & req_ready);

    always_comb begin
        write_n_d    = 1'b1;
        data_in_d    = data_in_q;
        last_grant_d = last_grant_q;
        if (transfer) begin
            write_n_d    = 1'b0;
            data_in_d    = gnt_data;
            last_grant_d = gnt_idx;
        end
        err_ovf_d = err_ovf_q | (!write_n_q && (bus_io.fifo_counter == CntW'(Depth)));
    end

    assign out_valid = (oq_cnt_q != '0);
    assign oq_push   = cap_q;
    assign oq_pop    = out_valid & bus_io.out_ready;

    always_comb begin
        read_n_d = !rd_issue;
        cap_d    = !read_n_q;
        oq_cnt_d = oq_cnt_q;
        if (oq_push && !oq_pop) begin
            oq_cnt_d = oq_cnt_q + QCntW'(1);
        end else if (!oq_push && oq_pop) begin
            oq_cnt_d = oq_cnt_q - QCntW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            write_n_q    <= 1'b1;
            data_in_q    <= '0;
            last_grant_q <= GntW'(NumReq - 1);
            err_ovf_q    <= 1'b0;
            read_n_q     <= 1'b1;
            cap_q        <= 1'b0;
            oq_wr_ptr_q  <= '0;
            oq_rd_ptr_q  <= '0;
            oq_cnt_q     <= '0;
            for (int i = 0; i < int'(OqDepth); i++) begin
                oq_mem_q[i] <= '0;
            end
        end else begin
            write_n_q    <= write_n_d;
            data_in_q    <= data_in_d;
            last_grant_q <= last_grant_d;
            err_ovf_q    <= err_ovf_d;
            read_n_q     <= read_n_d;
            cap_q        <= cap_d;
            oq_cnt_q     <= oq_cnt_d;
            if (oq_push) begin
                oq_mem_q[oq_wr_ptr_q] <= bus_io.fifo_data_out;
                oq_wr_ptr_q           <= oq_wr_ptr_q + QPtrW'(1);
            end
            if (oq_pop) begin
                oq_rd_ptr_q <= oq_rd_ptr_q + QPtrW'(1);
            end
        end
    end

    assign bus_io.req_ready    = req_ready;
    assign bus_io.fifo_data_in = data_in_q;
    assign bus_io.fifo_write_n = write_n_q;
    assign bus_io.fifo_read_n  = read_n_q;
    assign bus_io.out_valid    = out_valid;
    assign bus_io.out_data     = oq_mem_q[oq_rd_ptr_q];
    assign bus_io.last_grant   = last_grant_q;
    assign bus_io.err_ovf      = err_ovf_q;
endmodule

// File: tb/tb_sfifo_rr_ctrl.sv
// ---------------------------------------------------------------------------------------------
// tb_sfifo_rr_ctrl: self-checking bench for sfifo_rr_ctrl with a behavioural sfifo beside it.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Accepted producer words go into a scoreboard queue and are compared on consumer pops.
// ---------------------------------------------------------------------------------------------
module tb_sfifo_rr_ctrl;
    localparam int unsigned NumReq = 4;
    localparam int unsigned Width  = 8;
    localparam int unsigned Depth  = 16;
    localparam int unsigned CntW   = 5;

    logic clock;
    logic reset_n;

    sfifo_rr_ctrl_if #(.NumReq(NumReq), .Width(Width), .CntW(CntW)) bus ();

    sfifo_rr_ctrl #(
        .NumReq (NumReq),
        .Width  (Width),
        .Depth  (Depth),
        .CntW   (CntW),
        .OqDepth(4)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus_io (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Behavioural sfifo: registered data_out, counter holds on simultaneous read and write.
    logic [7:0] fmem [16];
    logic [3:0] fwp, frp;
    logic [4:0] fcnt;
    logic [7:0] fdout;
    logic       f_wr, f_rd;
    assign f_wr = !bus.fifo_write_n && (fcnt < 5'd16);
    assign f_rd = !bus.fifo_read_n && (fcnt != 5'd0);
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fcnt  <= '0;
            fwp   <= '0;
            frp   <= '0;
            fdout <= '0;
        end else begin
            if (f_wr) begin
                fmem[fwp] <= bus.fifo_data_in;
                fwp       <= fwp + 4'd1;
            end
            if (f_rd) begin
                fdout <= fmem[frp];
                frp   <= frp + 4'd1;
            end
            fcnt <= fcnt + 5'(f_wr) - 5'(f_rd);
        end
    end
    assign bus.fifo_counter  = fcnt;
    assign bus.fifo_data_out = fdout;

    typedef struct packed {
        logic [3:0] rv;
        logic [3:0] exp_ready;
        logic [1:0] exp_lg;
    } vec_t;

    vec_t       tbl [12];
    logic [7:0] sb [$];
    int         n_checks, errors;
    int         n_acc, n_rd, n_pop;
    int         cnt_max;
    logic [3:0] s_ready;
    logic       s_out_valid;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: sample at the falling edge, return 1 unit after the next rising edge.
    task automatic tick();
        @(negedge clock);
        s_ready     = bus.req_ready;
        s_out_valid = bus.out_valid;
        if (!reset_n) begin
            sb.delete();
        end else begin
            check("grant_onehot", 32'($countones(bus.req_ready) <= 1), 32'd1);
            for (int i = 0; i < 4; i++) begin
                if (bus.req_valid[i] && bus.req_ready[i]) begin
                    sb.push_back(bus.req_data[i*8 +: 8]);
                    n_acc++;
                end
            end
            if (!bus.fifo_read_n) n_rd++;
            if (bus.out_valid && bus.out_ready) begin
                n_pop++;
                if (sb.size() == 0) check("pop_unexpected", 32'(bus.out_data), 32'hFFFF_FFFF);
                else check("out_order", 32'(bus.out_data), 32'(sb.pop_front()));
            end
            if (int'(bus.fifo_counter) > cnt_max) cnt_max = int'(bus.fifo_counter);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.drain_en  = 1'b0;
        bus.out_ready = 1'b0;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        idle_inputs();
        repeat (2) tick();
        reset_n = 1'b1;
    endtask

    task automatic drain(input int max_cyc);
        bus.req_valid = '0;
        bus.drain_en  = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < max_cyc && (sb.size() != 0 || bus.fifo_counter != 0); i++) tick();
        check("drain_sb_empty", 32'(sb.size()), 32'd0);
        check("drain_cnt_zero", 32'(bus.fifo_counter), 32'd0);
    endtask

    task automatic set_data(input logic [7:0] d0, d1, d2, d3);
        bus.req_data = {d3, d2, d1, d0};
    endtask

    initial begin
        int acc0, rd0, pop0, pop_mid, first_ov;
        n_checks = 0; errors = 0; n_acc = 0; n_rd = 0; n_pop = 0; cnt_max = 0;
        reset_n = 1'b0;
        idle_inputs();

        // Reset values
        repeat (2) tick();
        check("rst_write_n", 32'(bus.fifo_write_n), 32'd1);
        check("rst_read_n", 32'(bus.fifo_read_n), 32'd1);
        check("rst_data_in", 32'(bus.fifo_data_in), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data", 32'(bus.out_data), 32'd0);
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        check("rst_last_grant", 32'(bus.last_grant), 32'd3);
        check("rst_err_ovf", 32'(bus.err_ovf), 32'd0);
        reset_n = 1'b1;

        // Single producer 0 word
        bus.req_valid = 4'b0001;
        set_data(8'h11, 8'h00, 8'h00, 8'h00);
        tick();
        check("t1_ready", 32'(s_ready), 32'b0001);
        check("t1_write_n", 32'(bus.fifo_write_n), 32'd0);
        check("t1_data_in", 32'(bus.fifo_data_in), 32'h11);
        check("t1_last_grant", 32'(bus.last_grant), 32'd0);
        bus.req_valid = '0;
        tick();
        check("t1_write_n_off", 32'(bus.fifo_write_n), 32'd1);
        check("t1_data_hold", 32'(bus.fifo_data_in), 32'h11);
        drain(60);

        // Table-driven arbitration with drain running so room never runs out
        tbl[0]  = '{4'b0001, 4'b0001, 2'd0};
        tbl[1]  = '{4'b1111, 4'b0010, 2'd1};
        tbl[2]  = '{4'b1111, 4'b0100, 2'd2};
        tbl[3]  = '{4'b1111, 4'b1000, 2'd3};
        tbl[4]  = '{4'b1111, 4'b0001, 2'd0};
        tbl[5]  = '{4'b0000, 4'b0000, 2'd0};
        tbl[6]  = '{4'b1001, 4'b1000, 2'd3};
        tbl[7]  = '{4'b1001, 4'b0001, 2'd0};
        tbl[8]  = '{4'b0100, 4'b0100, 2'd2};
        tbl[9]  = '{4'b0110, 4'b0010, 2'd1};
        tbl[10] = '{4'b0110, 4'b0100, 2'd2};
        tbl[11] = '{4'b1010, 4'b1000, 2'd3};
        apply_reset();
        bus.drain_en  = 1'b1;
        bus.out_ready = 1'b1;
        for (int v = 0; v < 12; v++) begin
            bus.req_valid = tbl[v].rv;
            set_data(8'(v*16 + 1), 8'(v*16 + 2), 8'(v*16 + 3), 8'(v*16 + 4));
            tick();
            check("tbl_ready", 32'(s_ready), 32'(tbl[v].exp_ready));
            check("tbl_last_grant", 32'(bus.last_grant), 32'(tbl[v].exp_lg));
        end
        drain(60);

        // All four requesting until the sfifo fills
        apply_reset();
        acc0 = n_acc;
        bus.req_valid = 4'b1111;
        for (int i = 0; i < 24; i++) begin
            set_data(8'(i*4 + 1), 8'(i*4 + 2), 8'(i*4 + 3), 8'(i*4 + 4));
            tick();
            if (s_ready != 4'b0000)
                check("rr_grant", 32'(s_ready), 32'd1 << ((n_acc - acc0 - 1) % 4));
        end
        check("fill_accepts", 32'(n_acc - acc0), 32'd16);
        check("fill_ready_off", 32'(s_ready), 32'd0);
        check("fill_counter", 32'(bus.fifo_counter), 32'd16);
        check("fill_err_ovf", 32'(bus.err_ovf), 32'd0);

        // Full sfifo, consumer stalled: exactly four reads fill the output side
        bus.req_valid = '0;
        bus.drain_en  = 1'b1;
        rd0 = n_rd;
        repeat (20) tick();
        check("stall_reads", 32'(n_rd - rd0), 32'd4);
        check("stall_counter", 32'(bus.fifo_counter), 32'd12);
        check("stall_out_valid", 32'(bus.out_valid), 32'd1);
        check("stall_out_data", 32'(bus.out_data), 32'h01);
        repeat (5) tick();
        check("stall_data_held", 32'(bus.out_data), 32'h01);
        check("stall_no_more_reads", 32'(n_rd - rd0), 32'd4);
        drain(100);

        // Read latency and ordering of A0..A3
        apply_reset();
        bus.req_valid = 4'b1111;
        set_data(8'hA0, 8'hA1, 8'hA2, 8'hA3);
        repeat (4) tick();
        bus.req_valid = '0;
        repeat (3) tick();
        check("lat_counter", 32'(bus.fifo_counter), 32'd4);
        pop0 = n_pop;
        first_ov = -1;
        bus.drain_en  = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i == 0) check("lat_read_n", 32'(bus.fifo_read_n), 32'd0);
            if (s_out_valid && first_ov < 0) first_ov = i;
        end
        check("lat_first_valid", 32'(first_ov), 32'd3);
        check("lat_pops", 32'(n_pop - pop0), 32'd4);
        drain(40);

        // Streaming producer 2 at one word per cycle
        apply_reset();
        bus.drain_en  = 1'b1;
        bus.out_ready = 1'b1;
        bus.req_valid = 4'b0100;
        acc0 = n_acc;
        pop_mid = n_pop;
        cnt_max = 0;
        for (int i = 0; i < 40; i++) begin
            set_data(8'h00, 8'h00, 8'(8'h80 + i), 8'h00);
            tick();
            if (i == 9) pop_mid = n_pop;
        end
        check("stream_accepts", 32'(n_acc - acc0), 32'd40);
        check("stream_pops", 32'(n_pop - pop_mid), 32'd30);
        check("stream_cnt_le2", 32'(cnt_max <= 2), 32'd1);
        drain(40);

        // Reset pulse mid-burst
        apply_reset();
        bus.drain_en  = 1'b1;
        bus.out_ready = 1'b1;
        bus.req_valid = 4'b1111;
        set_data(8'hC0, 8'hC1, 8'hC2, 8'hC3);
        repeat (6) tick();
        reset_n = 1'b0;
        #1;
        check("mid_rst_write_n", 32'(bus.fifo_write_n), 32'd1);
        check("mid_rst_read_n", 32'(bus.fifo_read_n), 32'd1);
        check("mid_rst_data_in", 32'(bus.fifo_data_in), 32'd0);
        check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_out_data", 32'(bus.out_data), 32'd0);
        check("mid_rst_req_ready", 32'(bus.req_ready), 32'd0);
        check("mid_rst_last_grant", 32'(bus.last_grant), 32'd3);
        tick();
        reset_n = 1'b1;
        tick();
        check("post_rst_ready", 32'(s_ready), 32'b0001);
        check("post_rst_last_grant", 32'(bus.last_grant), 32'd0);
        drain(60);
        check("final_err_ovf", 32'(bus.err_ovf), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, errors);
        $finish;
    end
endmodule
